pick_issue_stage: RTL and testbench



---
 rtl/pick_issue_stage.sv | 120 ++++++++++++
 tb/tb_pick_issue_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pick_issue_stage.sv
// Issue stage behind the two-stage picker: grants picks into a 2-entry FIFO,
// issues the head to a fixed-occupancy FU and reports completion and in-flight entries.
module pick_issue_stage #(
    parameter int N    = 8,
    parameter int IDXW = 3,
    parameter int LAT  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pick_vld_i,
    input  logic [N-1:0]    pick_oh_i,
    output logic            grant_o,
    output logic            iss_vld_o,
    output logic [IDXW-1:0] iss_idx_o,
    output logic [N-1:0]    iss_oh_o,
    input  logic            iss_rdy_i,
    output logic            done_vld_o,
    output logic [N-1:0]    done_oh_o,
    output logic [N-1:0]    inflight_o,
    output logic            err_o
);

    localparam int BW = $clog2(LAT + 1);
    localparam logic [N-1:0] OH_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]    fifo_q [2];
    logic [N-1:0]    fifo_d [2];
    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]   busy_cnt_q, busy_cnt_d;
    logic            err_q, err_d;
    logic [LAT-1:0]  dp_vld_q;
    logic [N-1:0]    dp_oh_q [LAT];

    logic            grant, legal, pick_onehot, push, busy, iss_vld, fire;
    logic [N-1:0]    iss_oh, inflight;
    logic [IDXW-1:0] iss_idx;

    // The full check uses only registered count, so a same-cycle pop never opens the FIFO.
    assign grant       = pick_vld_i & (count_q != 2'd2);
    assign pick_onehot = (pick_oh_i != '0) && ((pick_oh_i & (pick_oh_i - OH_ONE)) == '0);
    assign legal       = pick_onehot && ((pick_oh_i & inflight) == '0);
    assign push        = grant & legal;
    assign busy        = (busy_cnt_q != '0);
    assign iss_oh      = fifo_q[rd_ptr_q];
    assign iss_vld     = (count_q != 2'd0) & ~busy;
    assign fire        = iss_vld & iss_rdy_i;

    always_comb begin
        iss_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (iss_oh[i]) iss_idx = iss_idx | IDXW'(i);
        end
    end

    // Popped slots are zeroed, so OR-ing both slots gives exactly the valid entries.
    always_comb begin
        inflight = fifo_q[0] | fifo_q[1];
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight | dp_oh_q[i];
        end
    end

    always_comb begin
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        if (push) fifo_d[wr_ptr_q] = pick_oh_i;
        if (fire) fifo_d[rd_ptr_q] = '0;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ fire;
        case ({push, fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (fire)      busy_cnt_d = BW'(LAT - 1);
        else if (busy) busy_cnt_d = busy_cnt_q - BW'(1);
        else           busy_cnt_d = busy_cnt_q;
        err_d = err_q | (grant & ~legal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
            dp_vld_q   <= '0;
            for (int i = 0; i < LAT; i++) dp_oh_q[i] <= '0;
        end else begin
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            busy_cnt_q <= busy_cnt_d;
            err_q      <= err_d;
            dp_vld_q[0] <= fire;
            dp_oh_q[0]  <= fire ? iss_oh : '0;
            for (int i = 1; i < LAT; i++) begin
                dp_vld_q[i] <= dp_vld_q[i-1];
                dp_oh_q[i]  <= dp_oh_q[i-1];
            end
        end
    end

    assign grant_o    = grant;
    assign iss_vld_o  = iss_vld;
    assign iss_idx_o  = iss_idx;
    assign iss_oh_o   = iss_oh;
    assign done_vld_o = dp_vld_q[LAT-1];
    assign done_oh_o  = dp_oh_q[LAT-1];
    assign inflight_o = inflight;
    assign err_o      = err_q;

endmodule

// File: tb/tb_pick_issue_stage.sv
// Directed bench for pick_issue_stage (N=8, LAT=2): each task drives one scenario
// and compares the full output bundle against hand-computed values each cycle.
module tb_pick_issue_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pick_vld;
    logic [7:0] pick_oh;
    logic       grant;
    logic       iss_vld;
    logic [2:0] iss_idx;
    logic [7:0] iss_oh;
    logic       iss_rdy;
    logic       done_vld;
    logic [7:0] done_oh;
    logic [7:0] inflight;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [30:0] exp_v;
    logic [30:0] obs;

    pick_issue_stage #(.N(8), .IDXW(3), .LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pick_vld_i (pick_vld),
        .pick_oh_i  (pick_oh),
        .grant_o    (grant),
        .iss_vld_o  (iss_vld),
        .iss_idx_o  (iss_idx),
        .iss_oh_o   (iss_oh),
        .iss_rdy_i  (iss_rdy),
        .done_vld_o (done_vld),
        .done_oh_o  (done_oh),
        .inflight_o (inflight),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    assign obs = {grant, iss_vld, iss_idx, iss_oh, done_vld, done_oh, inflight, err};

    // Packs expected outputs in the same order as obs.
    function automatic logic [30:0] ex(input logic g, input logic v, input logic [2:0] idx,
                                       input logic [7:0] oh, input logic dv, input logic [7:0] doh,
                                       input logic [7:0] inf, input logic e);
        return {g, v, idx, oh, dv, doh, inf, e};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        pick_vld = 1'b0;
        pick_oh = 8'h00;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pick_vld = 1'($urandom);
            pick_oh  = 8'($urandom);
            iss_rdy  = 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs[29:0] !== 30'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, obs[29:0], 30'd0);
            end
            tick();
        end
        pick_vld = 1'b0;
        pick_oh  = 8'h00;
        iss_rdy  = 1'b1;
        rst_n    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_v = ex(0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_release cyc%0d got=%h exp=%h", i, obs, exp_v);
            end
            tick();
        end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        logic [30:0] exp_seq [5];
        exp_seq[0] = ex(1, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0);
        exp_seq[1] = ex(0, 1, 3'd2, 8'h04, 0, 8'h00, 8'h04, 0);
        exp_seq[2] = ex(0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h04, 0);
        exp_seq[3] = ex(0, 0, 3'd0, 8'h00, 1, 8'h04, 8'h04, 0);
        exp_seq[4] = ex(0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0);
        iss_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            pick_vld = (c == 0);
            pick_oh  = (c == 0) ? 8'h04 : 8'h00;
            @(negedge clk);
            checks++;
            if (obs !== exp_seq[c]) begin
                errors++;
                $display("FAIL single cyc%0d got=%h exp=%h", c + 1, obs, exp_seq[c]);
            end
            tick();
        end
        $display("test_single: pick 0x04 issued and completed");
    endtask

    task automatic test_backpressure();
        logic        vld_seq [12];
        logic [7:0]  oh_seq  [12];
        logic        rdy_seq [12];
        logic [30:0] exp_seq [12];
        // cycles 0-3: iss_rdy low, picks 01, 02, 08 (held); cycle 4 onwards: iss_rdy high
        vld_seq = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        oh_seq  = '{8'h01, 8'h02, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rdy_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        exp_seq[0]  = ex(1, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0);
        exp_seq[1]  = ex(1, 1, 3'd0, 8'h01, 0, 8'h00, 8'h01, 0);
        exp_seq[2]  = ex(0, 1, 3'd0, 8'h01, 0, 8'h00, 8'h03, 0);
        exp_seq[3]  = ex(0, 1, 3'd0, 8'h01, 0, 8'h00, 8'h03, 0);
        exp_seq[4]  = ex(0, 1, 3'd0, 8'h01, 0, 8'h00, 8'h03, 0);
        exp_seq[5]  = ex(1, 0, 3'd1, 8'h02, 0, 8'h00, 8'h03, 0);
        exp_seq[6]  = ex(0, 1, 3'd1, 8'h02, 1, 8'h01, 8'h0B, 0);
        exp_seq[7]  = ex(0, 0, 3'd3, 8'h08, 0, 8'h00, 8'h0A, 0);
        exp_seq[8]  = ex(0, 1, 3'd3, 8'h08, 1, 8'h02, 8'h0A, 0);
        exp_seq[9]  = ex(0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h08, 0);
        exp_seq[10] = ex(0, 0, 3'd0, 8'h00, 1, 8'h08, 8'h08, 0);
        exp_seq[11] = ex(0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0);
        for (int c = 0; c < 12; c++) begin
            pick_vld = vld_seq[c];
            pick_oh  = oh_seq[c];
            iss_rdy  = rdy_seq[c];
            @(negedge clk);
            checks++;
            if (obs !== exp_seq[c]) begin
                errors++;
                $display("FAIL backpressure cyc%0d got=%h exp=%h", c, obs, exp_seq[c]);
            end
            tick();
        end
        $display("test_backpressure: picks 01 02 08 issued in order");
    endtask

    task automatic test_illegal();
        iss_rdy  = 1'b1;
        pick_vld = 1'b1;
        pick_oh  = 8'h06;
        @(negedge clk);
        exp_v = ex(1, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL illegal_grant got=%h exp=%h", obs, exp_v);
        end
        tick();
        pick_vld = 1'b0;
        pick_oh  = 8'h00;
        exp_v = ex(0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 1);
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL illegal_sticky cyc%0d got=%h exp=%h", c, obs, exp_v);
            end
            tick();
        end
        $display("test_illegal: pick 0x06 rejected, err sticky");
    endtask

    task automatic test_duplicate();
        logic        vld_seq [6];
        logic [30:0] exp_seq [6];
        vld_seq = '{1, 0, 1, 0, 0, 0};
        exp_seq[0] = ex(1, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0);
        exp_seq[1] = ex(0, 1, 3'd4, 8'h10, 0, 8'h00, 8'h10, 0);
        exp_seq[2] = ex(1, 0, 3'd0, 8'h00, 0, 8'h00, 8'h10, 0);
        exp_seq[3] = ex(0, 0, 3'd0, 8'h00, 1, 8'h10, 8'h10, 1);
        exp_seq[4] = ex(0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 1);
        exp_seq[5] = ex(0, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 1);
        iss_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            pick_vld = vld_seq[c];
            pick_oh  = vld_seq[c] ? 8'h10 : 8'h00;
            @(negedge clk);
            checks++;
            if (obs !== exp_seq[c]) begin
                errors++;
                $display("FAIL duplicate cyc%0d got=%h exp=%h", c, obs, exp_seq[c]);
            end
            tick();
        end
        $display("test_duplicate: second 0x10 rejected, original completes");
    endtask

    task automatic test_midreset();
        logic        vld_seq [4];
        logic [7:0]  oh_seq  [4];
        logic        rdy_seq [4];
        logic [30:0] exp_seq [4];
        vld_seq = '{1, 1, 0, 1};
        oh_seq  = '{8'h01, 8'h02, 8'h00, 8'h04};
        rdy_seq = '{0, 0, 1, 0};
        exp_seq[0] = ex(1, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0);
        exp_seq[1] = ex(1, 1, 3'd0, 8'h01, 0, 8'h00, 8'h01, 0);
        exp_seq[2] = ex(0, 1, 3'd0, 8'h01, 0, 8'h00, 8'h03, 0);
        exp_seq[3] = ex(1, 0, 3'd1, 8'h02, 0, 8'h00, 8'h03, 0);
        for (int c = 0; c < 4; c++) begin
            pick_vld = vld_seq[c];
            pick_oh  = oh_seq[c];
            iss_rdy  = rdy_seq[c];
            @(negedge clk);
            checks++;
            if (obs !== exp_seq[c]) begin
                errors++;
                $display("FAIL midreset_setup cyc%0d got=%h exp=%h", c, obs, exp_seq[c]);
            end
            if (c < 3) tick();
        end
        // Busy with a done pulse pending: pulse reset between clock edges.
        #1;
        rst_n    = 1'b0;
        pick_vld = 1'b0;
        pick_oh  = 8'h00;
        #2;
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL midreset_async got=%h exp=%h", obs, 31'd0);
        end
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 31'd0) begin
                errors++;
                $display("FAIL midreset_after cyc%0d got=%h exp=%h", c, obs, 31'd0);
            end
            tick();
        end
        $display("test_midreset: state cleared, pending done dropped");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        pick_vld = 1'b0;
        pick_oh  = 8'h00;
        iss_rdy  = 1'b0;
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_illegal();
        apply_reset();
        test_duplicate();
        apply_reset();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
